// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_pkg;

  localparam int unsigned RF_NREG = 32;
  localparam int unsigned RF_AW   = 5;
  localparam int unsigned RF_DW   = 32;

  localparam int unsigned ARB_RR      = 0;
  localparam int unsigned ARB_FIXED_B = 1;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } rr_ptr_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way grant logic for the writeback port: round-robin or fixed B-over-A.
module wb_rr_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic CLK,
  input  logic RESET,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  rr_ptr_t rr_ptr;
  logic    contested;

  assign contested = a_valid & b_valid;

  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (!RESET) begin
      if (contested) begin
        if (ARB_MODE == ARB_FIXED_B || rr_ptr == PTR_B) b_grant = 1'b1;
        else                                           a_grant = 1'b1;
      end else begin
        a_grant = a_valid;
        b_grant = b_valid;
      end
    end
  end

  // Pointer only advances when both requesters competed for the port.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rr_ptr <= PTR_A;
    end else if (ARB_MODE == ARB_RR && contested) begin
      rr_ptr <= (rr_ptr == PTR_A) ? PTR_B : PTR_A;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between WB (A) and load return (B),
// and tracks outstanding load destinations in a pending-write scoreboard.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NREG     = RF_NREG,
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_data,
  output logic            b_ready,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_addr,
  output logic            rf_write,
  output logic [AW-1:0]   rf_addr,
  output logic [DW-1:0]   rf_data,
  output logic [NREG-1:0] busy_mask,
  output logic            sb_err
);

  logic            a_xfer;
  logic            b_xfer;
  logic [NREG-1:0] busy_nxt;
  logic            err_nxt;

  wb_rr_arbiter #(
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .CLK    (CLK),
    .RESET  (RESET),
    .a_valid(a_valid),
    .b_valid(b_valid),
    .a_grant(a_ready),
    .b_grant(b_ready)
  );

  assign a_xfer = a_valid & a_ready;
  assign b_xfer = b_valid & b_ready;

  // Clear for the returning load is applied before the new alloc, so a
  // same-edge re-alloc of the returning register is neither an error nor lost.
  always_comb begin
    busy_nxt = busy_mask;
    err_nxt  = sb_err;
    if (b_xfer && b_addr != '0) begin
      if (!busy_mask[b_addr]) err_nxt = 1'b1;
      busy_nxt[b_addr] = 1'b0;
    end
    if (alloc_valid && alloc_addr != '0) begin
      if (busy_nxt[alloc_addr]) err_nxt = 1'b1;
      busy_nxt[alloc_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busy_mask <= '0;
      sb_err    <= 1'b0;
    end else begin
      busy_mask <= busy_nxt;
      sb_err    <= err_nxt;
    end
  end

  // x0 writes are accepted but never reach the register file.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
    end else if (a_xfer) begin
      rf_write <= (a_addr != '0);
      rf_addr  <= a_addr;
      rf_data  <= a_data;
    end else if (b_xfer) begin
      rf_write <= (b_addr != '0);
      rf_addr  <= b_addr;
      rf_data  <= b_data;
    end else begin
      rf_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter (round-robin and fixed-priority).
module tb_regfile_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        a_valid, b_valid, alloc_valid;
  logic [4:0]  a_addr, b_addr, alloc_addr;
  logic [31:0] a_data, b_data;

  logic        a_ready0, b_ready0, rf_write0, sb_err0;
  logic [4:0]  rf_addr0;
  logic [31:0] rf_data0, busy0;
  logic        a_ready1, b_ready1, rf_write1, sb_err1;
  logic [4:0]  rf_addr1;
  logic [31:0] rf_data1, busy1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter #(.ARB_MODE(0)) dut_rr (
    .CLK(CLK), .RESET(RESET),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready0),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready0),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .rf_write(rf_write0), .rf_addr(rf_addr0), .rf_data(rf_data0),
    .busy_mask(busy0), .sb_err(sb_err0)
  );

  regfile_wb_arbiter #(.ARB_MODE(1)) dut_fx (
    .CLK(CLK), .RESET(RESET),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready1),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready1),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .rf_write(rf_write1), .rf_addr(rf_addr1), .rf_data(rf_data1),
    .busy_mask(busy1), .sb_err(sb_err1)
  );

  typedef struct {
    logic        av; logic [4:0] aa; logic [31:0] ad;
    logic        bv; logic [4:0] ba; logic [31:0] bd;
    logic        lv; logic [4:0] la;
    logic        ear, ebr, ew; logic [4:0] eaddr; logic [31:0] edata;
    logic        cad; logic [31:0] ebusy; logic eerr; logic fx;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    alloc_valid = 0; alloc_addr = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    //          av aa ad        bv ba bd     lv la  ear ebr ew eaddr edata    cad ebusy  eerr fx
    tbl[0]  = '{1, 3, 32'h5F,   0, 0, 0,     0, 0,  1,  0,  1, 3,    32'h5F,  1, 32'h0,  0, 0};
    tbl[1]  = '{0, 0, 0,        0, 0, 0,     0, 0,  0,  0,  0, 3,    32'h5F,  1, 32'h0,  0, 0};
    tbl[2]  = '{1, 0, 32'hFFFF, 0, 0, 0,     1, 0,  1,  0,  0, 0,    0,       0, 32'h0,  0, 0};
    tbl[3]  = '{0, 0, 0,        0, 0, 0,     1, 6,  0,  0,  0, 0,    0,       0, 32'h40, 0, 0};
    tbl[4]  = '{0, 0, 0,        0, 0, 0,     0, 0,  0,  0,  0, 0,    0,       0, 32'h40, 0, 0};
    tbl[5]  = '{0, 0, 0,        0, 0, 0,     0, 0,  0,  0,  0, 0,    0,       0, 32'h40, 0, 0};
    tbl[6]  = '{0, 0, 0,        1, 6, 32'h32,0, 0,  0,  1,  1, 6,    32'h32,  1, 32'h0,  0, 0};
    tbl[7]  = '{0, 0, 0,        0, 0, 0,     1, 6,  0,  0,  0, 6,    32'h32,  1, 32'h40, 0, 0};
    tbl[8]  = '{0, 0, 0,        1, 6, 32'h33,1, 6,  0,  1,  1, 6,    32'h33,  1, 32'h40, 0, 0};
    tbl[9]  = '{1, 1, 32'h1C,   1, 2, 32'h6C,0, 0,  1,  0,  1, 1,    32'h1C,  1, 32'h40, 0, 1};
    tbl[10] = '{1, 1, 32'h1C,   1, 2, 32'h6C,0, 0,  0,  1,  1, 2,    32'h6C,  1, 32'h40, 1, 1};
    tbl[11] = '{1, 1, 32'h1C,   1, 2, 32'h6C,0, 0,  1,  0,  1, 1,    32'h1C,  1, 32'h40, 1, 1};
    tbl[12] = '{1, 1, 32'h1C,   1, 2, 32'h6C,0, 0,  0,  1,  1, 2,    32'h6C,  1, 32'h40, 1, 1};
    tbl[13] = '{0, 0, 0,        0, 0, 0,     0, 0,  0,  0,  0, 2,    32'h6C,  1, 32'h40, 1, 0};

    // Reset state, with requests asserted during reset.
    clear_inputs();
    RESET = 1;
    a_valid = 1; b_valid = 1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_a_ready", a_ready0, 0);
    chk("rst_b_ready", b_ready0, 0);
    chk("rst_rf_write", rf_write0, 0);
    chk("rst_rf_addr", rf_addr0, 0);
    chk("rst_rf_data", rf_data0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_sb_err", sb_err0, 0);
    clear_inputs();
    #2 RESET = 0;
    tick();

    for (int i = 0; i < 14; i++) begin
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      alloc_valid = tbl[i].lv; alloc_addr = tbl[i].la;
      #1;
      chk($sformatf("row%0d_a_ready", i), a_ready0, tbl[i].ear);
      chk($sformatf("row%0d_b_ready", i), b_ready0, tbl[i].ebr);
      if (tbl[i].fx) begin
        chk($sformatf("row%0d_fixed_a_ready", i), a_ready1, 0);
        chk($sformatf("row%0d_fixed_b_ready", i), b_ready1, 1);
      end
      tick();
      chk($sformatf("row%0d_rf_write", i), rf_write0, tbl[i].ew);
      if (tbl[i].cad) begin
        chk($sformatf("row%0d_rf_addr", i), rf_addr0, tbl[i].eaddr);
        chk($sformatf("row%0d_rf_data", i), rf_data0, tbl[i].edata);
      end
      chk($sformatf("row%0d_busy", i), busy0, tbl[i].ebusy);
      chk($sformatf("row%0d_sb_err", i), sb_err0, tbl[i].eerr);
      if (tbl[i].fx) begin
        chk($sformatf("row%0d_fixed_rf_addr", i), rf_addr1, 2);
        chk($sformatf("row%0d_fixed_rf_data", i), rf_data1, 32'h6C);
      end
    end

    // B return to a register that was never allocated.
    do_reset();
    b_valid = 1; b_addr = 9; b_data = 1;
    tick();
    clear_inputs();
    chk("errb_sb_err", sb_err0, 1);
    chk("errb_rf_write", rf_write0, 1);
    chk("errb_rf_addr", rf_addr0, 9);
    repeat (3) tick();
    chk("errb_sticky", sb_err0, 1);

    // Double alloc of the same register.
    do_reset();
    chk("err_cleared_by_reset", sb_err0, 0);
    alloc_valid = 1; alloc_addr = 4;
    tick();
    chk("alloc4_busy", busy0, 32'h10);
    chk("alloc4_no_err", sb_err0, 0);
    tick();
    clear_inputs();
    chk("alloc4_twice_err", sb_err0, 1);
    tick();
    chk("alloc4_err_sticky", sb_err0, 1);

    // Asynchronous reset in the middle of a transfer; pointer must return to A.
    do_reset();
    a_valid = 1; a_addr = 5; a_data = 32'hAA;
    b_valid = 1; b_addr = 0; b_data = 0;
    alloc_valid = 1; alloc_addr = 7;
    tick();
    alloc_valid = 0;
    chk("mid_pre_rf_write", rf_write0, 1);
    chk("mid_pre_rf_addr", rf_addr0, 5);
    chk("mid_pre_busy", busy0, 32'h80);
    #3 RESET = 1;
    #1;
    chk("mid_rf_write", rf_write0, 0);
    chk("mid_rf_addr", rf_addr0, 0);
    chk("mid_busy", busy0, 0);
    chk("mid_a_ready", a_ready0, 0);
    chk("mid_b_ready", b_ready0, 0);
    #1 RESET = 0;
    #1;
    chk("post_rst_a_ready", a_ready0, 1);
    chk("post_rst_b_ready", b_ready0, 0);
    tick();
    chk("post_rst_rf_write", rf_write0, 1);
    chk("post_rst_rf_addr", rf_addr0, 5);
    chk("post_rst_rf_data", rf_data0, 32'hAA);
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
